// File: rtl/umem_dp_if.sv
// Core load/store port and AXI byte-strobed write channel of the unified memory.
// Latency: none, this file only groups wires.
// Backpressure: cpu_ready gates core requests and axi_wready gates AXI writes.
interface umem_dp_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [2:0]        cpu_f3;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ready;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;
  logic              cpu_err;
  logic              axi_wvalid;
  logic              axi_wready;
  logic [ADDR_W-1:0] axi_waddr;
  logic [31:0]       axi_wdata;
  logic [3:0]        axi_wstrb;

  // Requester side: the core and the AXI master.
  modport master (
    output cpu_req, cpu_we, cpu_f3, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_err,
    output axi_wvalid, axi_waddr, axi_wdata, axi_wstrb,
    input  axi_wready
  );

  // Memory side.
  modport slave (
    input  cpu_req, cpu_we, cpu_f3, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rvalid, cpu_rdata, cpu_err,
    input  axi_wvalid, axi_waddr, axi_wdata, axi_wstrb,
    output axi_wready
  );
endinterface

// File: rtl/umem_dp.sv
// Byte-addressable unified memory with a core load/store port and an AXI write port.
// Latency: the load/store response (cpu_rvalid) arrives 1 cycle after accept; AXI writes land on the accept edge.
// Backpressure: both ports are held off during CLEAR; a core store stalls AXI for that cycle.
module umem_dp #(
  parameter int              ADDR_W       = 32,
  parameter int              DEPTH        = 512,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'hA000_0000,
  parameter bit              CLEAR_ON_RST = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  output logic      busy,
  umem_dp_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W - 2;

  typedef enum logic [0:0] {S_CLEAR, S_IDLE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] clr_cnt, clr_cnt_nxt;
  logic             clear_we;

  logic [7:0]       mem [DEPTH];

  logic [ADDR_W-1:0] cpu_off, axi_off;
  logic [IDX_W-1:0]  cidx, aidx;
  logic              cpu_in_range, axi_in_range;
  logic [3:0]        cpu_bmask;
  logic              cpu_bad, cpu_acc, cpu_st;
  logic              axi_wr;
  logic [3:0][7:0]   ld_byte;
  logic [31:0]       ld_ext;

  // State and clear-pointer register; reset (re)starts the clear at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state and port readiness; with clearing disabled CLEAR is a one-cycle hold-off.
  always_comb begin
    state_nxt      = state;
    clr_cnt_nxt    = clr_cnt;
    clear_we       = 1'b0;
    busy           = 1'b0;
    bus.cpu_ready  = 1'b0;
    bus.axi_wready = 1'b0;
    case (state)
      S_CLEAR: begin
        if (CLEAR_ON_RST) begin
          busy        = 1'b1;
          clear_we    = 1'b1;
          clr_cnt_nxt = clr_cnt + 1'b1;
          if (&clr_cnt) state_nxt = S_IDLE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        bus.cpu_ready  = !rst;
        bus.axi_wready = !rst && !(bus.cpu_req && bus.cpu_we);
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Address decode: offset from base gives both the range check and the wrapped index.
  always_comb begin
    cpu_off      = bus.cpu_addr - BASE_ADDR;
    axi_off      = bus.axi_waddr - BASE_ADDR;
    cpu_in_range = cpu_off < ADDR_W'(DEPTH);
    axi_in_range = axi_off < ADDR_W'(DEPTH);
    cidx         = cpu_off[IDX_W-1:0];
    aidx         = axi_off[IDX_W-1:0];
    case (bus.cpu_f3)
      3'b000, 3'b100: cpu_bmask = 4'b0001;
      3'b001, 3'b101: cpu_bmask = 4'b0011;
      3'b010:         cpu_bmask = 4'b1111;
      default:        cpu_bmask = 4'b0000;
    endcase
    cpu_bad = (cpu_bmask == 4'b0000) || !cpu_in_range;
    cpu_acc = bus.cpu_req && bus.cpu_ready;
    cpu_st  = cpu_acc && bus.cpu_we && !cpu_bad;
    axi_wr  = bus.axi_wvalid && bus.axi_wready && axi_in_range;
  end

  // Load bytes, forwarding any AXI byte written on the same edge (write-first).
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ld_byte[k] = mem[cidx + IDX_W'(k)];
      for (int j = 0; j < 4; j++) begin
        if (axi_wr && bus.axi_wstrb[j] &&
            (aidx + IDX_W'(j)) == (cidx + IDX_W'(k)))
          ld_byte[k] = bus.axi_wdata[8*j +: 8];
      end
    end
    case (bus.cpu_f3)
      3'b000:  ld_ext = {{24{ld_byte[0][7]}}, ld_byte[0]};
      3'b001:  ld_ext = {{16{ld_byte[1][7]}}, ld_byte[1], ld_byte[0]};
      3'b010:  ld_ext = ld_byte;
      3'b100:  ld_ext = {24'h0, ld_byte[0]};
      3'b101:  ld_ext = {16'h0, ld_byte[1], ld_byte[0]};
      default: ld_ext = 32'h0;
    endcase
  end

  // Byte array writes: clear word, core store and AXI lanes (store and AXI never coincide).
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (clear_we && !rst)
        mem[{clr_cnt, 2'(k)}] <= 8'h00;
      if (cpu_st && cpu_bmask[k])
        mem[cidx + IDX_W'(k)] <= bus.cpu_wdata[8*k +: 8];
      if (axi_wr && bus.axi_wstrb[k])
        mem[aidx + IDX_W'(k)] <= bus.axi_wdata[8*k +: 8];
    end
  end

  // Response register; data and error hold between responses, reset drops in-flight loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_rdata  <= 32'h0;
      bus.cpu_err    <= 1'b0;
    end else begin
      bus.cpu_rvalid <= cpu_acc;
      if (cpu_acc) begin
        bus.cpu_err   <= cpu_bad;
        bus.cpu_rdata <= (cpu_bad || bus.cpu_we) ? 32'h0 : ld_ext;
      end
    end
  end
endmodule

// File: tb/tb_umem_dp.sv
// Directed bench for umem_dp: clear, sized loads/stores, AXI wrap and strobes, collisions, errors.
// Inputs change on the falling edge; outputs are sampled on falling edges.
// Summary line counts every comparison and every failure.
module tb_umem_dp;
  localparam logic [31:0] BASE = 32'hA000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_chk = 0;
  int   n_fail = 0;

  umem_dp_if #(.ADDR_W(32)) bus ();

  umem_dp #(
    .ADDR_W(32), .DEPTH(512), .BASE_ADDR(BASE), .CLEAR_ON_RST(1'b1)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .busy (busy),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // One core access: present for one cycle, return the response seen a cycle later.
  task automatic cpu_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic rv, output logic [31:0] rd,
                        output logic er);
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_f3 = f3;
    bus.cpu_addr = addr; bus.cpu_wdata = wd;
    @(negedge clk);
    rv = bus.cpu_rvalid; rd = bus.cpu_rdata; er = bus.cpu_err;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
  endtask

  // One AXI write, holding valid until ready is seen (bounded).
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, output logic ok);
    ok = 1'b0;
    @(negedge clk);
    bus.axi_wvalid = 1'b1; bus.axi_waddr = addr; bus.axi_wdata = wd; bus.axi_wstrb = strb;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.axi_wready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus.axi_wvalid = 1'b0;
  endtask

  // Count falling edges until busy drops (bounded).
  task automatic wait_clear(output int cycles);
    cycles = 0;
    while (busy && cycles < 1000) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    int cyc;
    logic rv, er;
    logic [31:0] rd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b exp 1", busy); end
    n_chk++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready: got %b exp 0", bus.cpu_ready); end
    n_chk++; if (bus.axi_wready !== 1'b0) begin n_fail++; $display("FAIL rst_axi_wready: got %b exp 0", bus.axi_wready); end
    n_chk++; if (bus.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b exp 0", bus.cpu_rvalid); end
    n_chk++; if (bus.cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", bus.cpu_rdata); end
    n_chk++; if (bus.cpu_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", bus.cpu_err); end
    rst = 1'b0;
    wait_clear(cyc);
    n_chk++; if (cyc !== 128) begin n_fail++; $display("FAIL clear_cycles: got %0d exp 128", cyc); end
    n_chk++; if (bus.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cpu_ready: got %b exp 1", bus.cpu_ready); end
    cpu_op(1'b0, 3'b010, BASE + 32'h100, 32'h0, rv, rd, er);
    n_chk++; if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL clear_lw100: got rv=%b err=%b %h exp rv=1 err=0 00000000", rv, er, rd); end
    cpu_op(1'b0, 3'b010, BASE + 32'h1FC, 32'h0, rv, rd, er);
    n_chk++; if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL clear_lw1fc: got rv=%b err=%b %h exp rv=1 err=0 00000000", rv, er, rd); end
  endtask

  task automatic test_load_ext;
    logic rv, er;
    logic [31:0] rd;
    cpu_op(1'b1, 3'b010, BASE + 32'h10, 32'hDEADBEEF, rv, rd, er);
    n_chk++; if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL sw_resp: got rv=%b err=%b %h exp rv=1 err=0 00000000", rv, er, rd); end
    cpu_op(1'b0, 3'b000, BASE + 32'h10, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL lb_sext: got %h exp FFFFFFEF", rd); end
    @(negedge clk);
    n_chk++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b0, 32'hFFFFFFEF}) begin n_fail++; $display("FAIL rdata_hold: got rv=%b %h exp rv=0 FFFFFFEF", bus.cpu_rvalid, bus.cpu_rdata); end
    cpu_op(1'b0, 3'b100, BASE + 32'h13, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'h000000DE) begin n_fail++; $display("FAIL lbu: got %h exp 000000DE", rd); end
    cpu_op(1'b0, 3'b101, BASE + 32'h11, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'h0000ADBE) begin n_fail++; $display("FAIL lhu: got %h exp 0000ADBE", rd); end
    cpu_op(1'b0, 3'b001, BASE + 32'h12, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL lh_sext: got %h exp FFFFDEAD", rd); end
    cpu_op(1'b0, 3'b010, BASE + 32'h10, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw: got %h exp DEADBEEF", rd); end
    cpu_op(1'b1, 3'b000, BASE + 32'h20, 32'h12345680, rv, rd, er);
    cpu_op(1'b0, 3'b010, BASE + 32'h20, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL sb_only_byte0: got %h exp 00000080", rd); end
  endtask

  task automatic test_axi_wrap;
    logic ok, rv, er;
    logic [31:0] rd;
    axi_write(BASE + 32'h1FE, 32'h11223344, 4'b1111, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL axi_wrap_ready: got %b exp 1", ok); end
    cpu_op(1'b0, 3'b010, BASE + 32'h1FE, 32'h0, rv, rd, er);
    n_chk++; if ({er, rd} !== {1'b0, 32'h11223344}) begin n_fail++; $display("FAIL axi_wrap_lw: got err=%b %h exp err=0 11223344", er, rd); end
    cpu_op(1'b0, 3'b100, BASE + 32'h0, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'h00000022) begin n_fail++; $display("FAIL axi_wrap_idx0: got %h exp 00000022", rd); end
    cpu_op(1'b0, 3'b010, BASE + 32'h1FF, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'h00112233) begin n_fail++; $display("FAIL wrap_misaligned_lw: got %h exp 00112233", rd); end
    axi_write(BASE + 32'h40, 32'hAABBCCDD, 4'b0101, ok);
    cpu_op(1'b0, 3'b010, BASE + 32'h40, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'h00BB00DD) begin n_fail++; $display("FAIL axi_strobe: got %h exp 00BB00DD", rd); end
  endtask

  task automatic test_collision;
    logic rv, er;
    logic [31:0] rd;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_f3 = 3'b010;
    bus.cpu_addr = BASE + 32'h80; bus.cpu_wdata = 32'hCAFEF00D;
    bus.axi_wvalid = 1'b1; bus.axi_waddr = BASE + 32'h90; bus.axi_wdata = 32'h55667788; bus.axi_wstrb = 4'hF;
    #1;
    n_chk++; if (bus.axi_wready !== 1'b0) begin n_fail++; $display("FAIL coll_wready_low: got %b exp 0", bus.axi_wready); end
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    n_chk++; if ({bus.cpu_rvalid, bus.cpu_err} !== 2'b10) begin n_fail++; $display("FAIL coll_store_resp: got rv=%b err=%b exp rv=1 err=0", bus.cpu_rvalid, bus.cpu_err); end
    #1;
    n_chk++; if (bus.axi_wready !== 1'b1) begin n_fail++; $display("FAIL coll_wready_next: got %b exp 1", bus.axi_wready); end
    @(negedge clk);
    bus.axi_wvalid = 1'b0;
    cpu_op(1'b0, 3'b010, BASE + 32'h80, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL coll_cpu_data: got %h exp CAFEF00D", rd); end
    cpu_op(1'b0, 3'b010, BASE + 32'h90, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'h55667788) begin n_fail++; $display("FAIL coll_axi_data: got %h exp 55667788", rd); end
    // Load and AXI write to the same word on the same edge: load sees new bytes.
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_f3 = 3'b010; bus.cpu_addr = BASE + 32'h90;
    bus.axi_wvalid = 1'b1; bus.axi_waddr = BASE + 32'h90; bus.axi_wdata = 32'h99AABBCC; bus.axi_wstrb = 4'hF;
    #1;
    n_chk++; if (bus.axi_wready !== 1'b1) begin n_fail++; $display("FAIL ld_axi_wready: got %b exp 1", bus.axi_wready); end
    @(negedge clk);
    bus.cpu_req = 1'b0; bus.axi_wvalid = 1'b0;
    n_chk++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 32'h99AABBCC}) begin n_fail++; $display("FAIL write_first: got rv=%b %h exp rv=1 99AABBCC", bus.cpu_rvalid, bus.cpu_rdata); end
  endtask

  task automatic test_errors;
    logic ok, rv, er;
    logic [31:0] rd;
    cpu_op(1'b0, 3'b010, BASE - 32'h4, 32'h0, rv, rd, er);
    n_chk++; if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL oor_load: got rv=%b err=%b %h exp rv=1 err=1 00000000", rv, er, rd); end
    cpu_op(1'b1, 3'b011, BASE + 32'h10, 32'h0, rv, rd, er);
    n_chk++; if ({rv, er} !== 2'b11) begin n_fail++; $display("FAIL bad_f3_err: got rv=%b err=%b exp rv=1 err=1", rv, er); end
    cpu_op(1'b0, 3'b010, BASE + 32'h10, 32'h0, rv, rd, er);
    n_chk++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin n_fail++; $display("FAIL bad_f3_nowrite: got err=%b %h exp err=0 DEADBEEF", er, rd); end
    cpu_op(1'b1, 3'b010, BASE + 32'h200, 32'hFFFFFFFF, rv, rd, er);
    n_chk++; if ({rv, er, rd} !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL oor_store_err: got rv=%b err=%b %h exp rv=1 err=1 00000000", rv, er, rd); end
    axi_write(BASE + 32'h200, 32'hFFFFFFFF, 4'hF, ok);
    n_chk++; if (ok !== 1'b1) begin n_fail++; $display("FAIL oor_axi_accept: got %b exp 1", ok); end
    cpu_op(1'b0, 3'b010, BASE + 32'h0, 32'h0, rv, rd, er);
    n_chk++; if (rd !== 32'h00001122) begin n_fail++; $display("FAIL oor_nowrite: got %h exp 00001122", rd); end
  endtask

  task automatic test_reset_mid_clear;
    int cyc;
    logic seen_rv;
    logic rv, er;
    logic [31:0] rd;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_f3 = 3'b010; bus.cpu_addr = BASE + 32'h10;
    rst = 1'b1;
    @(negedge clk);
    bus.cpu_req = 1'b0; rst = 1'b0;
    n_chk++; if ({bus.cpu_rvalid, busy} !== 2'b01) begin n_fail++; $display("FAIL dropped_load: got rv=%b busy=%b exp rv=0 busy=1", bus.cpu_rvalid, busy); end
    seen_rv = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.cpu_rvalid) seen_rv = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (busy && cyc < 1000) begin
      @(negedge clk);
      if (bus.cpu_rvalid) seen_rv = 1'b1;
      cyc++;
    end
    n_chk++; if (cyc !== 128) begin n_fail++; $display("FAIL mid_clear_cycles: got %0d exp 128", cyc); end
    n_chk++; if (seen_rv !== 1'b0) begin n_fail++; $display("FAIL no_rvalid_in_clear: got %b exp 0", seen_rv); end
    cpu_op(1'b0, 3'b010, BASE + 32'h10, 32'h0, rv, rd, er);
    n_chk++; if ({rv, er, rd} !== {1'b1, 1'b0, 32'h0}) begin n_fail++; $display("FAIL reclear_lw: got rv=%b err=%b %h exp rv=1 err=0 00000000", rv, er, rd); end
  endtask

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_f3 = 3'b000;
    bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.axi_wvalid = 1'b0; bus.axi_waddr = 32'h0; bus.axi_wdata = 32'h0; bus.axi_wstrb = 4'h0;
    test_reset();
    test_load_ext();
    test_axi_wrap();
    test_collision();
    test_errors();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
